fetch_stage: RTL and testbench

Instruction-fetch front end of the pipelined RV32I core. It owns the PC, issues instruction-memory requests over a req/gnt/rvalid handshake, and delivers instruction words through the IF/ID pipeline register to the main decoder, which consumes instr_d[6:0] as op. It handles decode stalls, flushes and execute-stage redirects for branches and jumps. At most one memory request is outstanding at a time.

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared constants for the RV32I fetch front end: FSM encoding and reset/NOP defaults.
package rv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; invalid slots carry a NOP.
module if_id_reg import rv_fetch_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load && !stall) begin
      instr_d   = instr_in;
      pc_d      = pc_in;
      pcplus4_d = pc_in + XLEN'(4);
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, runs a single-outstanding req/gnt/rvalid handshake,
// and feeds IF/ID, handling decode stalls, flushes and execute redirects.
module fetch_stage import rv_fetch_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pcsrc_e,
  input  logic [XLEN-1:0] pctarget_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d, pc_req_q, pc_req_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
  logic            ld, ifid_flush;
  logic [XLEN-1:0] ld_instr, ld_pc;

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_req_d     = pc_req_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    ld           = 1'b0;
    ld_instr     = imem_rdata;
    ld_pc        = pc_req_q;
    imem_req     = (state_q == S_REQ) && !stall_f && !pcsrc_e;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: if (imem_req && imem_gnt) begin
        pc_req_d = pc_f_q;
        pc_f_d   = pc_f_q + XLEN'(4);
        state_d  = S_WAIT;
      end
      S_WAIT: if (imem_rvalid) begin
        if (!stall_d) begin
          ld      = 1'b1;
          state_d = S_REQ;
        end else begin
          hold_instr_d = imem_rdata;
          hold_pc_d    = pc_req_q;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: if (!stall_d) begin
        ld       = 1'b1;
        ld_instr = hold_instr_q;
        ld_pc    = hold_pc_q;
        state_d  = S_REQ;
      end
      S_DROP: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over everything; only a still-unreturned response forces DROP.
    if (pcsrc_e) begin
      pc_f_d       = pctarget_e & ALIGN_MASK;
      ld           = 1'b0;
      hold_instr_d = NOP_INSTR;
      hold_pc_d    = '0;
      state_d      = ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) ? S_DROP : S_REQ;
    end

    // A same-cycle load is younger than whatever flush_d is killing.
    ifid_flush = pcsrc_e || (flush_d && !ld);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_f_q       <= RESET_PC;
      pc_req_q     <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pc_req_q     <= pc_req_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_addr = pc_f_q & ALIGN_MASK;

  if_id_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall_d),
    .flush     (ifid_flush),
    .load      (ld),
    .instr_in  (ld_instr),
    .pc_in     (ld_pc),
    .instr_o   (instr_d),
    .pc_o      (pc_d),
    .pcplus4_o (pcplus4_d),
    .valid_o   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios plus a randomized run checked against a slot-level fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stall_f = 0, stall_d = 0, flush_d = 0, pcsrc_e = 0;
  logic        imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] pctarget_e = 0, imem_rdata = 0;
  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pcplus4_d;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'hA5A5_0F0F) + 32'h0000_1357;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (instr_d !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_d, NOP); end
    n_tests++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_d); end
    n_tests++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc_d: got %h want 0", pc_d); end
    n_tests++; if (pcplus4_d !== 32'h0) begin n_fail++; $display("FAIL reset_pcplus4: got %h want 0", pcplus4_d); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req0: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0050_0093; settle();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req: got %b want 0", imem_req); end
    tick(); imem_rvalid = 0;
    n_tests++; if (instr_d !== 32'h0050_0093 || valid_d !== 1'b1) begin n_fail++; $display("FAIL basic_instr0: got %h/%b want 00500093/1", instr_d, valid_d); end
    n_tests++; if (pc_d !== 32'h0 || pcplus4_d !== 32'h4) begin n_fail++; $display("FAIL basic_pc0: got %h/%h want 0/4", pc_d, pcplus4_d); end
    settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_req1: got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h00A0_0113; tick(); imem_rvalid = 0;
    n_tests++; if (instr_d !== 32'h00A0_0113 || pc_d !== 32'h4 || pcplus4_d !== 32'h8) begin n_fail++; $display("FAIL basic_instr1: got %h pc=%h p4=%h want 00a00113 pc=4 p4=8", instr_d, pc_d, pcplus4_d); end
  endtask

  task automatic test_hold();
    settle();
    n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL hold_req_addr: got %h want 8", imem_addr); end
    imem_gnt = 1; tick(); imem_gnt = 0;
    stall_d = 1; imem_rvalid = 1; imem_rdata = 32'h0030_0193; tick(); imem_rvalid = 0;
    settle();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem_req); end
    n_tests++; if (instr_d !== 32'h00A0_0113 || pc_d !== 32'h4) begin n_fail++; $display("FAIL hold_ifid_kept: got %h pc=%h want 00a00113 pc=4", instr_d, pc_d); end
    tick(); tick();
    stall_d = 0; tick();
    n_tests++; if (instr_d !== 32'h0030_0193 || pc_d !== 32'h8 || valid_d !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %h pc=%h v=%b want 00300193 pc=8 v=1", instr_d, pc_d, valid_d); end
    settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL hold_next_req: got req=%b addr=%h want 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1; tick(); imem_gnt = 0;
    pcsrc_e = 1; pctarget_e = 32'h103; tick(); pcsrc_e = 0;
    n_tests++; if (valid_d !== 1'b0 || instr_d !== NOP) begin n_fail++; $display("FAIL redir_ifid: got %h/%b want 00000013/0", instr_d, valid_d); end
    settle();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_drop_req: got %b want 0", imem_req); end
    tick();
    imem_rvalid = 1; imem_rdata = 32'h1234_5678; tick(); imem_rvalid = 0;
    n_tests++; if (valid_d !== 1'b0 || instr_d !== NOP) begin n_fail++; $display("FAIL redir_dropped: got %h/%b want 00000013/0", instr_d, valid_d); end
    settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_next_req: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_same();
    imem_gnt = 1; tick(); imem_gnt = 0;
    pcsrc_e = 1; pctarget_e = 32'h100; imem_rvalid = 1; imem_rdata = 32'hCAFE_0093;
    tick(); pcsrc_e = 0; imem_rvalid = 0;
    n_tests++; if (valid_d !== 1'b0 || instr_d !== NOP) begin n_fail++; $display("FAIL same_ifid: got %h/%b want 00000013/0", instr_d, valid_d); end
    settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL same_next_req: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
  endtask

  task automatic test_stall_f_flush();
    stall_f = 1; imem_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stallf_req%0d: got %b want 0", i, imem_req); end
      tick();
    end
    stall_f = 0; settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL stallf_pc_kept: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
    tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0010_0213; tick(); imem_rvalid = 0;
    n_tests++; if (valid_d !== 1'b1 || pc_d !== 32'h100 || instr_d !== 32'h0010_0213) begin n_fail++; $display("FAIL stallf_fetch: got %h pc=%h v=%b want 00100213 pc=100 v=1", instr_d, pc_d, valid_d); end
    flush_d = 1; imem_gnt = 1; tick(); flush_d = 0; imem_gnt = 0;
    n_tests++; if (valid_d !== 1'b0 || instr_d !== NOP) begin n_fail++; $display("FAIL flush_ifid: got %h/%b want 00000013/0", instr_d, valid_d); end
    imem_rvalid = 1; imem_rdata = 32'h0020_0293; tick(); imem_rvalid = 0;
    n_tests++; if (valid_d !== 1'b1 || pc_d !== 32'h104 || instr_d !== 32'h0020_0293) begin n_fail++; $display("FAIL flush_continue: got %h pc=%h v=%b want 00200293 pc=104 v=1", instr_d, pc_d, valid_d); end
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1; tick(); imem_gnt = 0;
    rst = 1; #1;
    n_tests++; if (instr_d !== NOP || valid_d !== 1'b0 || pc_d !== 32'h0 || pcplus4_d !== 32'h0) begin n_fail++; $display("FAIL rstmid_ifid: got %h pc=%h p4=%h v=%b want reset values", instr_d, pc_d, pcplus4_d, valid_d); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", imem_req); end
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick();
    rst = 0; tick(); imem_rvalid = 0;
    n_tests++; if (valid_d !== 1'b0 || instr_d !== NOP) begin n_fail++; $display("FAIL rstmid_late: got %h/%b want 00000013/0", instr_d, valid_d); end
    settle();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  // Model: one outstanding slot, one ready slot, and the IF/ID contents.
  task automatic test_random();
    logic [31:0] m_pc, out_addr, rdy_pc, m_instr, m_pc_d, resp_addr;
    bit out_v, out_stale, rdy_v, m_valid, exp_req, resp, resp_stale;
    int out_cnt;
    rst = 1; tick(); rst = 0; tick();
    m_pc = 0; out_v = 0; out_stale = 0; out_addr = 0; out_cnt = 0; rdy_v = 0; rdy_pc = 0;
    m_valid = 0; m_instr = NOP; m_pc_d = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall_f = ($urandom_range(0, 3) == 0);
      stall_d = ($urandom_range(0, 3) == 0);
      flush_d = ($urandom_range(0, 9) == 0);
      pcsrc_e = ($urandom_range(0, 11) == 0);
      pctarget_e = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
      imem_gnt = 1'($urandom_range(0, 1));
      imem_rvalid = out_v && (out_cnt == 0);
      imem_rdata = imem_rvalid ? memf(out_addr) : $urandom;
      settle();
      exp_req = !out_v && !rdy_v && !stall_f && !pcsrc_e;
      n_tests++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, imem_req, exp_req); end
      if (exp_req) begin
        n_tests++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, imem_addr, m_pc); end
      end
      resp = imem_rvalid; resp_stale = out_stale; resp_addr = out_addr;
      if (resp) out_v = 0;
      else if (out_v) out_cnt--;
      if (pcsrc_e) begin
        m_pc = pctarget_e & ~32'h3;
        rdy_v = 0; m_valid = 0; m_instr = NOP;
        if (out_v) out_stale = 1;
      end else begin
        if (resp && !resp_stale) begin rdy_v = 1; rdy_pc = resp_addr; end
        if (rdy_v && !stall_d) begin
          m_valid = 1; m_instr = memf(rdy_pc); m_pc_d = rdy_pc; rdy_v = 0;
        end else if (flush_d) begin
          m_valid = 0; m_instr = NOP;
        end
        if (exp_req && imem_gnt) begin
          out_v = 1; out_addr = m_pc; out_cnt = $urandom_range(0, 2); out_stale = 0;
          m_pc = m_pc + 32'd4;
        end
      end
      tick();
      n_tests++; if (valid_d !== m_valid || instr_d !== m_instr) begin n_fail++; $display("FAIL rnd_ifid c%0d: got %h/%b want %h/%b", cyc, instr_d, valid_d, m_instr, m_valid); end
      if (m_valid) begin
        n_tests++; if (pc_d !== m_pc_d || pcplus4_d !== m_pc_d + 32'd4) begin n_fail++; $display("FAIL rnd_pc c%0d: got %h/%h want %h/%h", cyc, pc_d, pcplus4_d, m_pc_d, m_pc_d + 32'd4); end
      end
    end
    stall_f = 0; stall_d = 0; flush_d = 0; pcsrc_e = 0; imem_gnt = 0; imem_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_redirect_wait();
    test_redirect_same();
    test_stall_f_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
